// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI constants and the bridge state encoding.
//   state_t    : bridge FSM states
//   BURST_INCR : AXI INCR burst type
//   SIZE_8B    : AXI transfer size code for 8-byte beats
//   RESP_OKAY  : AXI OKAY response code
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_mem_bridge.sv
// axi_mem_bridge: converts a simple request/response port into AXI4
// transactions. It handles one transaction at a time. A request can be a
// single-beat 64-bit write or an INCR read burst of up to MAX_LEN+1 beats.
//   aclk, aresetn              : clock, asynchronous active-low reset
//   req_*                      : upstream request (valid/ready handshake)
//   resp_*                     : upstream response beats (one-entry register)
//   ar*, r*                    : AXI read address / read data channels
//   aw*, w*, b*                : AXI write address / write data / write response
module axi_mem_bridge
  import axi_pkg::*;
#(
  parameter logic [7:0] MAX_LEN = 8'd7
) (
  input  logic        aclk,
  input  logic        aresetn,
  // upstream request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  // upstream response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_last,
  output logic        resp_err,
  // AXI read address
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t     state;
  logic       rst_done;
  logic       aw_done;
  logic       w_done;
  logic       overrun;
  logic [7:0] beat_cnt;
  logic       r_hs;
  logic       aw_hs;
  logic       w_hs;
  logic       beat_err;

  assign arsize  = SIZE_8B;
  assign arburst = BURST_INCR;
  assign awlen   = 8'd0;
  assign awsize  = SIZE_8B;
  assign awburst = BURST_INCR;
  assign wlast   = 1'b1;

  // rst_done keeps req_ready low while reset is held. It also keeps it low
  // on the first edge after release, so a request is never taken in reset.
  assign req_ready = (state == ST_IDLE) && !resp_valid && rst_done;
  assign rready    = (state == ST_R) && (!resp_valid || resp_ready);

  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // A beat is in error in four cases:
  //   - the slave flags it;
  //   - rlast comes before beat arlen (early rlast);
  //   - beat arlen arrives without rlast;
  //   - the beat is in the drained tail after beat arlen (overrun is sticky).
  always_comb begin
    beat_err = (rresp != RESP_OKAY) || overrun || (rlast != (beat_cnt == arlen));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      rst_done   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      overrun    <= 1'b0;
      beat_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      arvalid    <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      // When the response is consumed the slot frees up. A load made later
      // in this block, on the same edge, takes priority over this clear.
      if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            beat_cnt <= '0;
            overrun  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            if (req_wen) begin
              awaddr  <= req_addr;
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= ST_AW_W;
            end else if (req_len > MAX_LEN) begin
              // Illegal length: return an error beat and issue no AXI traffic.
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_last  <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              araddr  <= req_addr;
              arlen   <= req_len;
              arvalid <= 1'b1;
              state   <= ST_AR;
            end
          end
        end

        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= ST_R;
          end
        end

        ST_R: begin
          if (r_hs) begin
            resp_valid <= 1'b1;
            resp_rdata <= rdata;
            resp_last  <= rlast;
            resp_err   <= beat_err;
            beat_cnt   <= beat_cnt + 8'd1;
            if (!rlast && (beat_cnt == arlen)) begin
              overrun <= 1'b1;
            end
            if (rlast) begin
              state <= ST_IDLE;
            end
          end
        end

        ST_AW_W: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // The handshake terms cover the case where the final handshake
          // happens on this edge, or where both complete together.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= ST_B;
          end
        end

        ST_B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_last  <= 1'b1;
            resp_err   <= (bresp != RESP_OKAY);
            state      <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_valid && resp_ready) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_bridge.sv
module tb_axi_mem_bridge;
  localparam logic [7:0] MAX_LEN = 8'd7;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_last, resp_err;
  logic [63:0] resp_rdata;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, rready;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;

  axi_mem_bridge #(.MAX_LEN(MAX_LEN)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_last(resp_last), .resp_err(resp_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        e;
  } beat_t;

  beat_t exp_q[$];
  beat_t act_log[$];
  logic [1:0] r_plan[$];

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_taken = 0;
  int exp_ar = 0, exp_aw = 0;

  logic [31:0] cur_addr;
  logic [7:0]  cur_len;
  logic [63:0] cur_wdata;
  logic [7:0]  cur_wstrb;

  // stimulus knobs: a negative value means random
  int k_ar_delay = -1, k_aw_delay = -1, k_w_delay = -1, k_mode = -1, k_rr_hold = 0;
  bit k_err_en = 1'b1, k_rr_rand = 1'b1;

  // slave memory: the beat at byte address a holds {a, a ^ DEADBEEF}
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a, a ^ 32'hDEADBEEF};
  endfunction

  // error rule for beat i of a burst of n beats when len+1 beats were asked for
  function automatic logic beat_err_model(input int i, input int n, input int len, input logic [1:0] rr);
    return (rr != 2'b00) || (i == n - 1 && i < len) || (i == len && i != n - 1) || (i > len);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- AXI slave + response compare (one process) ----------------
  logic [31:0] r_addr, ar_prev_addr;
  logic [7:0]  ar_prev_len;
  int r_idx, ar_wait, aw_wait, w_wait, nbeats, mode;
  bit r_took, b_took, aw_seen, w_seen, b_pending, ar_stall;
  logic [1:0] rr;
  beat_t act, e;

  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
    bvalid = 0; bresp = 0; resp_ready = 0;
    r_idx = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
    r_took = 0; b_took = 0; aw_seen = 0; w_seen = 0; b_pending = 0; ar_stall = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
        bvalid = 0; bresp = 0; resp_ready = 0;
        exp_q.delete(); r_plan.delete();
        r_idx = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        r_took = 0; b_took = 0; aw_seen = 0; w_seen = 0; b_pending = 0; ar_stall = 0;
      end else begin
        if (r_took) begin rvalid = 0; r_took = 0; end
        if (b_took) begin bvalid = 0; b_took = 0; end
        arready = (k_ar_delay < 0) ? ($urandom_range(0, 2) == 0) : (arvalid && ar_wait >= k_ar_delay);
        awready = (k_aw_delay < 0) ? ($urandom_range(0, 2) == 0) : (awvalid && aw_wait >= k_aw_delay);
        wready  = (k_w_delay < 0)  ? ($urandom_range(0, 2) == 0) : (wvalid && w_wait >= k_w_delay);
        if (!rvalid && r_plan.size() > 0 && (k_mode >= 0 || $urandom_range(0, 3) != 0)) begin
          rvalid = 1;
          rdata  = mem_word(r_addr + 32'(8 * r_idx));
          rresp  = r_plan[0];
          rlast  = (r_plan.size() == 1);
        end
        if (b_pending && !bvalid && $urandom_range(0, 1) == 1) begin
          bvalid = 1;
          bresp  = (k_err_en && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          exp_q.push_back('{64'd0, 1'b1, bresp != 2'b00});
        end
        if (resp_valid && k_rr_hold > 0) begin
          resp_ready = 0;
          k_rr_hold--;
        end else begin
          resp_ready = k_rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        #1;
        // Everything below is a handshake that completes on the coming rising edge.
        if (resp_valid && !resp_ready) check("rready_hold", 128'(rready), 128'(0));
        if (ar_stall) check("ar_stable", 128'({arvalid, araddr, arlen}), 128'({1'b1, ar_prev_addr, ar_prev_len}));
        if (bready) check("bready_phase", 128'(b_pending), 128'(1));

        if (arvalid && arready) begin
          ar_cnt++;
          check("ar_fields", 128'({araddr, arlen, arsize, arburst}), 128'({cur_addr, cur_len, 3'b011, 2'b01}));
          nbeats = int'(cur_len) + 1;
          mode = (k_mode < 0) ? int'($urandom_range(0, 5)) : k_mode;
          if (mode == 4 && cur_len > 0) nbeats = int'($urandom_range(1, int'(cur_len)));
          else if (mode == 5) nbeats = int'(cur_len) + 1 + int'($urandom_range(1, 3));
          r_addr = araddr;
          r_idx  = 0;
          for (int i = 0; i < nbeats; i++) begin
            rr = (k_err_en && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_plan.push_back(rr);
            exp_q.push_back('{mem_word(araddr + 32'(8 * i)), (i == nbeats - 1),
                              beat_err_model(i, nbeats, int'(cur_len), rr)});
          end
          ar_wait = 0;
        end else if (arvalid) begin
          ar_wait++;
        end
        ar_stall = arvalid && !arready;
        ar_prev_addr = araddr;
        ar_prev_len  = arlen;

        if (rvalid && rready) begin
          void'(r_plan.pop_front());
          r_idx++;
          r_taken++;
          r_took = 1;
        end

        if (awvalid && awready) begin
          aw_cnt++;
          check("aw_fields", 128'({awaddr, awlen, awsize, awburst}), 128'({cur_addr, 8'd0, 3'b011, 2'b01}));
          aw_seen = 1; aw_wait = 0;
        end else if (awvalid) begin
          aw_wait++;
        end
        if (wvalid && wready) begin
          w_cnt++;
          check("w_fields", 128'({wdata, wstrb, wlast}), 128'({cur_wdata, cur_wstrb, 1'b1}));
          w_seen = 1; w_wait = 0;
        end else if (wvalid) begin
          w_wait++;
        end
        if (aw_seen && w_seen) begin
          b_pending = 1; aw_seen = 0; w_seen = 0;
        end
        if (bvalid && bready) begin
          b_cnt++;
          b_pending = 0;
          b_took = 1;
        end

        if (resp_valid && resp_ready) begin
          act = '{resp_rdata, resp_last, resp_err};
          act_log.push_back(act);
          if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL resp_unexpected actual=%0h required=none", act);
          end else begin
            e = exp_q.pop_front();
            check("resp_beat", 128'(act), 128'(e));
            if (e.l) done_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    @(negedge aclk);
    #2 aresetn = 0;
    #1;
    check("reset_outputs", 128'({req_ready, resp_valid, resp_last, resp_err, resp_rdata,
                                 arvalid, awvalid, wvalid, rready, bready}), 128'(0));
    repeat (3) begin
      @(negedge aclk); #1;
      check("req_ready_in_reset", 128'(req_ready), 128'(0));
    end
    #1 aresetn = 1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [7:0] len,
                       input logic [63:0] wd, input logic [7:0] ws, input bit wait_done);
    int n;
    int d0;
    bit bad;
    cur_addr = addr; cur_len = len; cur_wdata = wd; cur_wstrb = ws;
    bad = !wen && (len > MAX_LEN);
    d0 = done_cnt;
    @(negedge aclk);
    req_valid = 1; req_wen = wen; req_addr = addr; req_len = len; req_wdata = wd; req_wstrb = ws;
    #1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge aclk); #1; n++;
    end
    if (!req_ready) begin
      checks++; fails++;
      $display("FAIL req_accept_timeout actual=0 required=1");
      req_valid = 0;
      do_reset();
      return;
    end
    if (wen) exp_aw++;
    else if (!bad) exp_ar++;
    if (bad) exp_q.push_back('{64'd0, 1'b1, 1'b1});
    @(posedge aclk);
    #1 req_valid = 0;
    if (bad) check("bad_len_next_cycle", 128'({resp_valid, resp_last, resp_err, arvalid}), 128'(4'b1110));
    if (wait_done) begin
      n = 0;
      while (done_cnt == d0 && n < 600) begin
        @(negedge aclk); n++;
      end
      if (done_cnt == d0) begin
        checks++; fails++;
        $display("FAIL txn_timeout actual=pending required=done");
        do_reset();
      end
    end
  endtask

  task automatic directed_knobs();
    k_rr_rand = 0; k_err_en = 0; k_mode = 0; k_ar_delay = 0; k_aw_delay = 0; k_w_delay = 0; k_rr_hold = 0;
  endtask

  int a0, b0, r0, n;

  initial begin
    req_valid = 0; req_wen = 0; req_addr = '0; req_len = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge aclk);
    #1;
    check("reset_state", 128'({req_ready, resp_valid, resp_last, resp_err, resp_rdata,
                               arvalid, awvalid, wvalid, rready, bready}), 128'(0));
    #1 aresetn = 1;

    // read burst, arready held off for two cycles
    directed_knobs();
    k_ar_delay = 2;
    act_log.delete();
    issue(1'b0, 32'h8000_0000, 8'd3, '0, '0, 1);
    check("rd4_beats", 128'(act_log.size()), 128'(4));
    if (act_log.size() == 4) begin
      check("rd4_beat0", 128'(act_log[0].d), 128'(64'h8000_0000_5EAD_BEEF));
      check("rd4_beat3", 128'(act_log[3].d), 128'(64'h8000_0018_5EAD_BEF7));
      check("rd4_last", 128'({act_log[3].l, act_log[2].l, act_log[1].l, act_log[0].l}), 128'(4'b1000));
      check("rd4_err", 128'({act_log[3].e, act_log[2].e, act_log[1].e, act_log[0].e}), 128'(4'b0000));
    end

    // write with address and data accepted in different cycles
    directed_knobs();
    k_aw_delay = 1; k_w_delay = 3;
    act_log.delete();
    b0 = b_cnt;
    issue(1'b1, 32'h8000_0008, 8'd0, 64'h1122_3344_5566_7788, 8'h0F, 1);
    check("wr_b_handshakes", 128'(b_cnt - b0), 128'(1));
    check("wr_resp_count", 128'(act_log.size()), 128'(1));
    if (act_log.size() == 1) check("wr_resp", 128'(act_log[0]), 128'({64'd0, 1'b1, 1'b0}));

    // upstream backpressure on a two-beat read
    directed_knobs();
    k_rr_hold = 5;
    act_log.delete();
    issue(1'b0, 32'h0000_1000, 8'd1, '0, '0, 1);
    check("bp_beats", 128'(act_log.size()), 128'(2));
    if (act_log.size() == 2) begin
      check("bp_beat0", 128'(act_log[0]), 128'({64'h0000_1000_DEAD_AEEF, 1'b0, 1'b0}));
      check("bp_beat1", 128'(act_log[1]), 128'({64'h0000_1008_DEAD_AEE7, 1'b1, 1'b0}));
    end

    // illegal length
    directed_knobs();
    act_log.delete();
    a0 = ar_cnt;
    issue(1'b0, 32'h0000_2000, 8'd9, '0, '0, 1);
    check("badlen_no_ar", 128'(ar_cnt - a0), 128'(0));
    check("badlen_resp_count", 128'(act_log.size()), 128'(1));
    if (act_log.size() == 1) check("badlen_resp", 128'(act_log[0]), 128'({64'd0, 1'b1, 1'b1}));

    // reset in the middle of a burst, then a clean read
    directed_knobs();
    r0 = r_taken;
    issue(1'b0, 32'h0000_4000, 8'd7, '0, '0, 0);
    n = 0;
    while (r_taken - r0 < 2 && n < 200) begin
      @(negedge aclk); n++;
    end
    check("midburst_reached", 128'(r_taken - r0 >= 2), 128'(1));
    do_reset();
    act_log.delete();
    issue(1'b0, 32'h0000_3000, 8'd2, '0, '0, 1);
    check("post_reset_beats", 128'(act_log.size()), 128'(3));
    if (act_log.size() == 3) begin
      check("post_reset_beat0", 128'(act_log[0]), 128'({64'h0000_3000_DEAD_8EEF, 1'b0, 1'b0}));
      check("post_reset_beat2_last", 128'(act_log[2].l), 128'(1));
    end

    // randomized traffic: random readiness, burst-length mismatches, error responses
    k_rr_rand = 1; k_err_en = 1; k_mode = -1; k_ar_delay = -1; k_aw_delay = -1; k_w_delay = -1; k_rr_hold = 0;
    for (int t = 0; t < 60; t++) begin
      issue(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h1FFF_FFFF), 3'b000},
            8'($urandom_range(0, 10)), {$urandom, $urandom}, 8'($urandom), 1);
    end

    repeat (5) @(negedge aclk);
    check("ar_count", 128'(ar_cnt), 128'(exp_ar));
    check("aw_count", 128'(aw_cnt), 128'(exp_aw));
    check("w_count", 128'(w_cnt), 128'(exp_aw));
    check("b_count", 128'(b_cnt), 128'(exp_aw));
    check("leftover_expected", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_mem_bridge.md
AXI_MEM_BRIDGE -- requirements
Module: axi_mem_bridge

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8'd7, meaning the largest legal req_len (beats-1) for a read burst.
REQ-002 SHALL have port aclk  in  1  clock; one clock domain, all logic on rising edge.
REQ-003 SHALL have port aresetn  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  upstream request valid.
REQ-005 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-006 req_wen  in  1  1=single-beat write, 0=read burst.
REQ-007 req_addr  in  32  byte address, 8-byte aligned.
REQ-008 req_len  in  8  read beats minus 1; ignored for writes.
REQ-009 req_wdata  in  64  write data.
REQ-010 req_wstrb  in  8  write byte strobes.
REQ-011 resp_valid  out  1  response beat valid.
REQ-012 resp_ready  in  1  upstream accepts response beat.
REQ-013 resp_rdata  out  64  read beat data; 0 for writes.
REQ-014 resp_last  out  1  final beat of a transaction; always 1 for writes.
REQ-015 resp_err  out  1  beat carries an error.
REQ-016 araddr/awaddr  out  32  AXI read/write address.
REQ-017 arlen/awlen  out  8  burst length; awlen constant 8'd0.
REQ-018 arsize/awsize  out  3  constant 3'b011.
REQ-019 arburst/awburst  out  2  constant 2'b01 (INCR).
REQ-020 arvalid/awvalid  out  1  address valid.
REQ-021 arready/awready  in  1  address ready.
REQ-022 rdata  in  64, rresp  in  2, rlast  in  1, rvalid  in  1: AXI read data.
REQ-023 rready  out  1  read data ready.
REQ-024 wdata  out  64, wstrb  out  8, wlast  out  1 (constant 1), wvalid  out  1: AXI write data.
REQ-025 wready  in  1  write data ready.
REQ-026 bresp  in  2, bvalid  in  1  write response; bready  out  1.

Function
REQ-027 SHALL implement FSM IDLE->AR->R->IDLE for reads and IDLE->AW_W->B->RESP->IDLE for writes, with one transaction outstanding; req_ready = (state==IDLE) && !resp_valid.
REQ-028 On acceptance SHALL register addr/len/wdata/wstrb; arvalid, or awvalid and wvalid together, assert on the next cycle, are registered, and hold stable until their ready is sampled high.
REQ-029 In AW_W SHALL track aw_done and w_done independently, including the case where both are accepted in the same cycle, and SHALL go to B only when both are done; bready=1 in B only.
REQ-030 In R, rready = !resp_valid || resp_ready (one-entry output register); each accepted beat loads resp_rdata and increments an 8-bit beat counter; resp_err = (rresp!=0).
REQ-031 The bridge SHALL leave R on the beat with rlast=1; if rlast arrives before beat req_len, or beat req_len arrives without rlast, resp_err=1 on that beat and resp_last=1 only on the rlast beat; extra beats after req_len are drained with error until rlast.
REQ-032 A read with req_len > MAX_LEN SHALL be accepted and SHALL return one beat in the next cycle with resp_err=1, resp_last=1, and no AXI traffic.
REQ-033 B-response SHALL produce one resp beat with resp_last=1 and resp_err=(bresp!=0); resp_valid SHALL hold until resp_ready.

Reset
REQ-034 On aresetn low (at any time, mid-burst included): state=IDLE; all valids/readys, resp_*, counter and flags = 0; the first request after reset SHALL be accepted only with aresetn high.

Structure
REQ-035 The shared package axi_pkg SHALL hold the state enum, BURST_INCR=2'b01, SIZE_8B=3'b011 and RESP_OKAY=2'b00; no sub-module; resp register inline.

Verification
REQ-036 Read addr 0x80000000, len 3, arready delayed 2 cycles -> arlen=3, 4 beats in order, resp_last only on beat 3, resp_err=0.
REQ-037 Write addr 0x80000008, wdata 0x1122334455667788, wstrb 0x0F; awready in cycle 1, wready in cycle 3 -> single bready handshake, one resp with resp_last=1.
REQ-038 Read len 1 with resp_ready low for 5 cycles -> rready low while output is held, no beat lost, data in order.
REQ-039 Read len 9 with MAX_LEN=7 -> no arvalid, single resp with resp_err=1.
REQ-040 aresetn low during beat 2 of a len-7 burst -> all outputs 0 immediately; a new read then completes normally.
